// File: rtl/regbank_pkg.sv
// Shared helpers for the arbitrated register bank.
// Index-width helper and round-robin pointer increment.
package regbank_pkg;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(
        input int unsigned n
    );
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Next round-robin pointer after a grant to id, wrapping at n.
    function automatic int unsigned rr_next(
        input int unsigned id,
        input int unsigned n
    );
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/regbank_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, winner index, owns the pointer.
// Ports: clk_i, rst_n_i, req_i, en_i -> gnt_o, gnt_id_o.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = clog2_min1(N)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_id_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Scan from ptr_q, wrapping modulo N; first valid wins.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = IW'(rr_next(32'(gnt_id_o), N));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regbank_arb.sv
// Register bank with round-robin arbitrated write port and a
// combinational read port. Ports: req_* write side, rd_* read side,
// gnt_id_o/gnt_vld_o grant status, err_o/err_clr_i sticky range error.
module regbank_arb
    import regbank_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned NUM_REG    = 8,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned AW         = clog2_min1(NUM_REG),
    localparam int unsigned IW         = clog2_min1(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*AW-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
    input  logic [AW-1:0]                 rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_dat_o,
    output logic [IW-1:0]                 gnt_id_o,
    output logic                          gnt_vld_o,
    output logic                          err_o,
    input  logic                          err_clr_i
);

    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  wr_oob;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] ent [NUM_REG];

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .req_i    (req_valid_i),
        .en_i     (1'b1),
        .gnt_o    (req_ready_o),
        .gnt_id_o (gnt_id_o)
    );

    assign gnt_vld_o = |req_valid_i;

    // Select the winner's address and data from the packed buses.
    always_comb begin
        wr_addr = '0;
        wr_dat  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i]) begin
                wr_addr = req_addr_i[i*AW +: AW];
                wr_dat  = req_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr_oob = (32'(wr_addr) >= NUM_REG);

    for (genvar r = 0; r < NUM_REG; r++) begin : g_ent
        logic                  ld;
        logic [DATA_WIDTH-1:0] ent_q;

        assign ld = gnt_vld_o & (wr_addr == AW'(r));

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                ent_q <= '0;
            end else if (ld) begin
                ent_q <= wr_dat;
            end
        end

        assign ent[r] = ent_q;
    end

    // Out-of-range read addresses fall through to zero.
    always_comb begin
        rd_dat_o = '0;
        for (int unsigned r = 0; r < NUM_REG; r++) begin
            if (rd_addr_i == AW'(r)) begin
                rd_dat_o = ent[r];
            end
        end
    end

    // A new error wins over a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (gnt_vld_o && wr_oob) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_regbank_arb.sv
// Directed bench for regbank_arb with NUM_REQ=4, NUM_REG=6.
// Expected values are hand-computed per step.
module tb_regbank_arb;

    localparam int NRQ = 4;
    localparam int NRG = 6;
    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int IW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NRQ-1:0]    vld;
    logic [NRQ-1:0]    rdy;
    logic [NRQ*AW-1:0] addr;
    logic [NRQ*DW-1:0] dat;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_dat;
    logic [IW-1:0]     gnt_id;
    logic              gnt_vld;
    logic              err;
    logic              err_clr;

    int n_chk;
    int n_fail;

    regbank_arb #(
        .NUM_REQ    (NRQ),
        .NUM_REG    (NRG),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (vld),
        .req_ready_o (rdy),
        .req_addr_i  (addr),
        .req_dat_i   (dat),
        .rd_addr_i   (rd_addr),
        .rd_dat_o    (rd_dat),
        .gnt_id_o    (gnt_id),
        .gnt_vld_o   (gnt_vld),
        .err_o       (err),
        .err_clr_i   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h",
                     tag, obs, exp);
        end
    endtask

    task automatic set_req(
        input int          i,
        input logic [2:0]  a,
        input logic [31:0] d
    );
        addr[i*AW +: AW] = a;
        dat[i*DW +: DW]  = d;
    endtask

    task automatic rd_chk(
        input string       tag,
        input logic [2:0]  a,
        input logic [31:0] e
    );
        rd_addr = a;
        #1;
        check(tag, rd_dat, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        vld     = '0;
        addr    = '0;
        dat     = '0;
        rd_addr = '0;
        err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset / idle
        for (int a = 0; a < NRG; a++) begin
            rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
        end
        check("idle_rdy", 32'(rdy), 32'h0);
        check("idle_vld", 32'(gnt_vld), 32'h0);
        check("idle_err", 32'(err), 32'h0);

        // All requesters, 8 cycles of round robin
        for (int i = 0; i < NRQ; i++) begin
            set_req(i, 3'(i), 32'hA0 + 32'(i));
        end
        vld = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_id%0d", k),
                  32'(gnt_id), 32'(k % 4));
            check($sformatf("rr_rdy%0d", k),
                  32'(rdy), 32'(1 << (k % 4)));
            check($sformatf("rr_vld%0d", k),
                  32'(gnt_vld), 32'h1);
            tick();
        end
        vld = '0;
        for (int a = 0; a < 4; a++) begin
            rd_chk($sformatf("rr_rd%0d", a),
                   3'(a), 32'hA0 + 32'(a));
        end

        // After grant to 3: 1 then 3
        tick();
        vld = 4'b1010;
        #1;
        check("p13_a", 32'(gnt_id), 32'd1);
        tick();
        check("p13_b", 32'(gnt_id), 32'd3);
        check("p13_rdy", 32'(rdy), 32'b1000);
        tick();

        // Requester 2 alone, three back-to-back grants
        vld = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("r2_id%0d", k), 32'(gnt_id), 32'd2);
            check($sformatf("r2_rdy%0d", k), 32'(rdy), 32'b0100);
            tick();
        end

        // Same-cycle read/write at address 5
        vld = 4'b0001;
        set_req(0, 3'd5, 32'h11);
        tick();
        set_req(0, 3'd5, 32'h22);
        rd_addr = 3'd5;
        #1;
        check("rw_old", rd_dat, 32'h11);
        tick();
        vld = '0;
        #1;
        check("rw_new", rd_dat, 32'h22);

        // Out-of-range write at address 7 from requester 1
        tick();
        vld = 4'b0010;
        set_req(1, 3'd7, 32'hDEAD);
        #1;
        check("oob_rdy", 32'(rdy), 32'b0010);
        check("oob_err0", 32'(err), 32'h0);
        tick();
        vld = '0;
        #1;
        check("oob_err1", 32'(err), 32'h1);
        rd_chk("oob_rd5", 3'd5, 32'h22);
        rd_chk("oob_rd1", 3'd1, 32'hA1);
        rd_chk("oob_rd7", 3'd7, 32'h0);
        tick();

        // Clear together with another bad write keeps the flag
        vld = 4'b0010;
        err_clr = 1'b1;
        #1;
        check("clr_bad_id", 32'(gnt_id), 32'd1);
        tick();
        vld = '0;
        err_clr = 1'b0;
        #1;
        check("clr_bad_err", 32'(err), 32'h1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("clr_err", 32'(err), 32'h0);

        // Burst, then reset mid-burst
        for (int i = 0; i < NRQ; i++) begin
            set_req(i, 3'(i), 32'hB0 + 32'(i));
        end
        vld = 4'b1111;
        #1;
        check("pre_id2", 32'(gnt_id), 32'd2);
        tick();
        check("pre_id3", 32'(gnt_id), 32'd3);
        rd_chk("pre_rd2", 3'd2, 32'hB2);
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < NRG; a++) begin
            rd_chk($sformatf("mrst_rd%0d", a), 3'(a), 32'h0);
        end
        check("mrst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_id", 32'(gnt_id), 32'd0);
        check("post_rdy", 32'(rdy), 32'b0001);
        tick();
        vld = '0;
        rd_chk("post_rd0", 3'd0, 32'hB0);
        rd_chk("post_rd1", 3'd1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_arb.md
# regbank_arb

Shared register bank with round-robin write arbitration. `NUM_REQ` requesters compete for one write port into a bank of `NUM_REG` entries, each `DATA_WIDTH` bits wide, built from asynchronously reset, load-enabled flops. One combinational read port is also provided. The block sits between multiple producers (CSR masters, DMA status writers) and the status/config storage they share.

## Interface
- `NUM_REQ`, 4: number of write requesters, ≥2
- `NUM_REG`, 8: number of bank entries, ≥2, need not be a power of 2
- `DATA_WIDTH`, 32: entry width
- `AW` (derived), `$clog2(NUM_REG)`: address width
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  NUM_REQ  per-requester write request
- `req_ready_o`  out  NUM_REQ  per-requester grant; one-hot or zero
- `req_addr_i`  in  NUM_REQ*AW  packed addresses; requester i at `[i*AW +: AW]`
- `req_dat_i`  in  NUM_REQ*DATA_WIDTH  packed write data
- `rd_addr_i`  in  AW  read address
- `rd_dat_o`  out  DATA_WIDTH  read data, combinational from bank
- `gnt_id_o`  out  `$clog2(NUM_REQ)`  index of the current winner; 0 when idle
- `gnt_vld_o`  out  1  a write happens this cycle
- `err_o`  out  1  sticky out-of-range write flag
- `err_clr_i`  in  1  clears `err_o`

## Operation
- Handshake: a write transfers on a rising edge where `req_valid_i[i] & req_ready_o[i]`. Requesters hold valid, address and data stable until ready is seen.
- Arbitration is combinational each cycle. The search starts at pointer `ptr`, wraps modulo NUM_REQ, and the first valid requester wins. `req_ready_o` is one-hot at the winner. `gnt_vld_o = |req_valid_i`.
- Pointer: on a grant, `ptr <= (winner+1) mod NUM_REQ`. With no grant, `ptr` holds.
- Write: on a grant with `addr < NUM_REG`, entry[addr] is loaded with the winner's data at the clock edge. Other entries hold.
- Out-of-range address (`addr ≥ NUM_REG`): the handshake still completes (ready asserted, pointer advances), no entry changes, and `err_o` is set.
- `err_o`: set has priority over `err_clr_i` in the same cycle. Clear takes effect on the next edge.
- Read: `rd_dat_o = entry[rd_addr_i]`. An out-of-range read returns 0.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.

## Timing
- Reset, asynchronous: all entries 0, `ptr`=0, `err_o`=0. Combinational outputs follow inputs during reset, but no writes occur while `rst_n_i` is low.
- Grant latency: 0 cycles (ready is combinational from valid and `ptr`). Write latency: data is visible on `rd_dat_o` 1 cycle after the accepting edge.
- Read and write to the same address in the same cycle: `rd_dat_o` shows the old value; the new value appears in the next cycle.
- Reset asserted mid-operation: any pending write is dropped and state is forced to reset values immediately. The first cycle after deassertion arbitrates from `ptr`=0.
- Single requester valid for consecutive cycles: it is granted every cycle (back-to-back writes, one per cycle).
- Combinational paths: valid→ready and addr→rd_dat only. There is no path from ready to valid.

## Structure
- Package `regbank_pkg`: the `rr_next` pointer-increment function and a localparam helper for the index width (`clog2` with a minimum of 1).
- Sub-module `rr_arbiter` (NUM_REQ): inputs `req`, enable; outputs one-hot `gnt` and `gnt_id`; owns `ptr`. Reusable elsewhere.
- Bank: a generate loop of load-enabled, async-reset registers, one per entry. The load-enable is the address decode ANDed with grant.

## Test plan
- Reset then idle: all reads return 0, `req_ready_o`=0, `gnt_vld_o`=0, `err_o`=0.
- All 4 requesters valid for 8 cycles, each writing its own address i with value 0xA0+i: grants go 0,1,2,3,0,1,2,3; entries 0..3 read 0xA0..0xA3.
- Requesters 1 and 3 valid after a grant to 3: the next grant goes to 1, then 3. Requester 2 valid alone for 3 cycles gets 3 consecutive grants.
- Same-cycle read/write at address 5 (old value 0x11, new 0x22): `rd_dat_o`=0x11 in that cycle and 0x22 in the next.
- With NUM_REG=6, a write to address 7: ready is asserted, no entry changes, `err_o`=1 from the next cycle. `err_clr_i` together with another bad write keeps `err_o`=1; `err_clr_i` alone gives `err_o`=0.
- `rst_n_i` pulsed low mid-burst after entries were written: all entries read 0 at once, and the first post-reset grant with all requesters valid goes to 0.
